// File: rtl/reg_univ.sv
// reg_univ: parametrised general-purpose datapath register.
// Supports hold, parallel load, logical/arithmetic shifts with serial in/out,
// increment/decrement with carry/borrow, synchronous clear, and a saturating
// count of shifts since the last load or clear.
module reg_univ #(
  parameter int               WIDTH     = 19,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             cout,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             shift_done,
  output logic             zero
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_SAR   = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH:0]   inc_sum;

  // Saturating successor of the shift count, so the count never wraps.
  always_comb begin
    cnt_next = shift_cnt;
    if (shift_cnt != CNT_MAX) begin
      cnt_next = shift_cnt + CNT_W'(1);
    end
  end

  assign inc_sum    = {1'b0, q} + (WIDTH + 1)'(1);
  assign shift_done = (shift_cnt == CNT_MAX);
  assign zero       = (q == '0);

  // Register update: one operation per enabled clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= RESET_VAL;
      sout      <= 1'b0;
      cout      <= 1'b0;
      shift_cnt <= '0;
    end else if (en) begin
      case (op)
        OP_HOLD: begin
        end
        OP_LOAD: begin
          q         <= d;
          sout      <= 1'b0;
          cout      <= 1'b0;
          shift_cnt <= '0;
        end
        OP_SHL: begin
          q         <= {q[WIDTH-2:0], sin};
          sout      <= q[WIDTH-1];
          shift_cnt <= cnt_next;
        end
        OP_SHR: begin
          q         <= {sin, q[WIDTH-1:1]};
          sout      <= q[0];
          shift_cnt <= cnt_next;
        end
        OP_SAR: begin
          q         <= {q[WIDTH-1], q[WIDTH-1:1]};
          sout      <= q[0];
          shift_cnt <= cnt_next;
        end
        OP_INC: begin
          q    <= inc_sum[WIDTH-1:0];
          cout <= inc_sum[WIDTH];
        end
        OP_DEC: begin
          q    <= q - WIDTH'(1);
          cout <= (q == '0);
        end
        OP_CLEAR: begin
          q         <= '0;
          sout      <= 1'b0;
          cout      <= 1'b0;
          shift_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_univ.sv
// tb_reg_univ: directed self-checking bench for reg_univ.
// Two instances share all inputs: one with the default reset value and one
// with a non-zero reset value, so reset and clear can be told apart.
module tb_reg_univ;

  localparam int W = 19;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    op;
  logic [W-1:0]  d;
  logic          sin;

  logic [W-1:0]  q;
  logic          sout;
  logic          cout;
  logic [CW-1:0] shift_cnt;
  logic          shift_done;
  logic          zero;

  logic [W-1:0]  rv_q;
  logic          rv_sout;
  logic          rv_cout;
  logic [CW-1:0] rv_shift_cnt;
  logic          rv_shift_done;
  logic          rv_zero;

  int passes;
  int checks;

  reg_univ #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin(sin),
    .q(q), .sout(sout), .cout(cout), .shift_cnt(shift_cnt),
    .shift_done(shift_done), .zero(zero)
  );

  reg_univ #(.WIDTH(W), .RESET_VAL(19'h00ABC)) dut_rv (
    .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin(sin),
    .q(rv_q), .sout(rv_sout), .cout(rv_cout), .shift_cnt(rv_shift_cnt),
    .shift_done(rv_shift_done), .zero(rv_zero)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one operation from a falling edge, let it take effect on the
  // rising edge, and return on the next falling edge ready to sample.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] dv,
                               input logic s, input logic e);
    op  = o;
    d   = dv;
    sin = s;
    en  = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    passes = 0;
    checks = 0;
    rst = 1'b1;
    en  = 1'b0;
    op  = 3'b000;
    d   = '0;
    sin = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Put something non-zero in, then reset asynchronously between edges.
    applyStimulus(3'b001, 19'h12345, 1'b0, 1'b1);
    applyStimulus(3'b010, 19'h00000, 1'b1, 1'b1);
    checkOutput("pre_reset_q", q, 19'h2468B);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_q", q, 19'h00000);
    checkOutput("async_rst_sout", sout, 1'b0);
    checkOutput("async_rst_cnt", shift_cnt, 5'd0);
    checkOutput("async_rst_rv_q", rv_q, 19'h00ABC);
    checkOutput("async_rst_zero", zero, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Load, then en=0 must freeze everything despite op=inc.
    applyStimulus(3'b001, 19'h5A5A5, 1'b0, 1'b1);
    checkOutput("load_q", q, 19'h5A5A5);
    for (int i = 0; i < 3; i++) applyStimulus(3'b101, 19'h00000, 1'b0, 1'b0);
    checkOutput("en0_q", q, 19'h5A5A5);
    checkOutput("en0_cnt", shift_cnt, 5'd0);
    checkOutput("en0_cout", cout, 1'b0);
    applyStimulus(3'b000, 19'h7FFFF, 1'b1, 1'b1);
    checkOutput("hold_q", q, 19'h5A5A5);

    // Increment/decrement wraparound with carry and borrow.
    applyStimulus(3'b001, 19'h7FFFF, 1'b0, 1'b1);
    applyStimulus(3'b101, 19'h00000, 1'b0, 1'b1);
    checkOutput("inc_wrap_q", q, 19'h00000);
    checkOutput("inc_wrap_cout", cout, 1'b1);
    checkOutput("inc_wrap_zero", zero, 1'b1);
    applyStimulus(3'b110, 19'h00000, 1'b0, 1'b1);
    checkOutput("dec_wrap_q", q, 19'h7FFFF);
    checkOutput("dec_wrap_cout", cout, 1'b1);
    checkOutput("dec_wrap_zero", zero, 1'b0);
    applyStimulus(3'b110, 19'h00000, 1'b0, 1'b1);
    checkOutput("dec_q", q, 19'h7FFFE);
    checkOutput("dec_cout", cout, 1'b0);
    applyStimulus(3'b101, 19'h00000, 1'b0, 1'b1);
    checkOutput("inc_q", q, 19'h7FFFF);
    checkOutput("inc_cout", cout, 1'b0);

    // Arithmetic, logical right and left shifts.
    applyStimulus(3'b001, 19'h40001, 1'b0, 1'b1);
    applyStimulus(3'b100, 19'h00000, 1'b0, 1'b1);
    checkOutput("sar_q", q, 19'h60000);
    checkOutput("sar_sout", sout, 1'b1);
    applyStimulus(3'b011, 19'h00000, 1'b0, 1'b1);
    checkOutput("shr_q", q, 19'h30000);
    checkOutput("shr_sout", sout, 1'b0);
    applyStimulus(3'b010, 19'h00000, 1'b1, 1'b1);
    checkOutput("shl_q", q, 19'h60001);
    checkOutput("shl_sout", sout, 1'b0);
    checkOutput("shift_cnt3", shift_cnt, 5'd3);
    applyStimulus(3'b011, 19'h00000, 1'b1, 1'b1);
    checkOutput("shr_sin1_q", q, 19'h70000);
    checkOutput("shr_sin1_sout", sout, 1'b1);

    // Walk a single one out through 19 left shifts; count saturates.
    applyStimulus(3'b001, 19'h00001, 1'b0, 1'b1);
    checkOutput("load_clears_cnt", shift_cnt, 5'd0);
    for (int i = 0; i < 18; i++) applyStimulus(3'b010, 19'h00000, 1'b0, 1'b1);
    checkOutput("shl18_q", q, 19'h40000);
    checkOutput("shl18_cnt", shift_cnt, 5'd18);
    checkOutput("shl18_done", shift_done, 1'b0);
    applyStimulus(3'b010, 19'h00000, 1'b0, 1'b1);
    checkOutput("shl19_q", q, 19'h00000);
    checkOutput("shl19_sout", sout, 1'b1);
    checkOutput("shl19_cnt", shift_cnt, 5'd19);
    checkOutput("shl19_done", shift_done, 1'b1);
    applyStimulus(3'b010, 19'h00000, 1'b1, 1'b1);
    checkOutput("shl20_cnt", shift_cnt, 5'd19);
    checkOutput("shl20_done", shift_done, 1'b1);
    checkOutput("shl20_q", q, 19'h00001);
    checkOutput("shl20_sout", sout, 1'b0);

    // Clear after a few shifts goes to zero, not to the reset value.
    applyStimulus(3'b001, 19'h12345, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(3'b010, 19'h00000, 1'b0, 1'b1);
    checkOutput("shl5_cnt", shift_cnt, 5'd5);
    applyStimulus(3'b111, 19'h00000, 1'b0, 1'b1);
    checkOutput("clear_q", q, 19'h00000);
    checkOutput("clear_cnt", shift_cnt, 5'd0);
    checkOutput("clear_rv_q", rv_q, 19'h00000);
    checkOutput("clear_zero", zero, 1'b1);

    // Reset in the middle of a shift sequence.
    applyStimulus(3'b001, 19'h0F0F0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(3'b011, 19'h00000, 1'b1, 1'b1);
    checkOutput("mid_cnt", rv_shift_cnt, 5'd3);
    op  = 3'b011;
    en  = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_rv_q", rv_q, 19'h00ABC);
    checkOutput("mid_rst_rv_cnt", rv_shift_cnt, 5'd0);
    checkOutput("mid_rst_rv_sout", rv_sout, 1'b0);
    checkOutput("mid_rst_q", q, 19'h00000);
    @(negedge clk);
    checkOutput("rst_held_rv_q", rv_q, 19'h00ABC);
    rst = 1'b0;
    applyStimulus(3'b101, 19'h00000, 1'b0, 1'b1);
    checkOutput("post_rst_inc_rv_q", rv_q, 19'h00ABD);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reg_univ.md
Name: reg_univ

Overview:
- Parametrised successor to the fixed 19-bit load register; it is the general-purpose datapath register for the arithmetic units (multiplier/divider A, Q and M registers, counters).
- Adds per-cycle operation select: hold, parallel load, logical and arithmetic shifts with serial in/out, increment/decrement with carry, and synchronous clear.
- Tracks the shifts performed since the last load or clear, so iterative shift-add controllers can detect completion without an external counter.

Parameters:
- WIDTH, 19, register width in bits; legal range WIDTH >= 2.
- RESET_VAL, 0, value q takes on asynchronous reset; WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the shift counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  clock enable; when 0 the whole block holds, regardless of op.
- op  input  3  operation select, encoding below.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for shl/shr.
- q  output  WIDTH  register contents.
- sout  output  1  registered bit shifted out by the last shift op.
- cout  output  1  registered carry (inc) or borrow (dec) of the last inc/dec op.
- shift_cnt  output  CNT_W  shifts performed since the last load or clear; saturates at WIDTH.
- shift_done  output  1  combinational, 1 when shift_cnt == WIDTH.
- zero  output  1  combinational, 1 when q == 0.

Behaviour:
- Reset (rst=1, asynchronous, any time, including mid-sequence): q=RESET_VAL, sout=0, cout=0, shift_cnt=0.
- All updates occur on the rising clk edge with en=1. Results are visible on q one cycle after op is sampled (latency 1).
- en=0: q, sout, cout and shift_cnt all hold.
- op encoding (takes effect when en=1):
  - 000 hold: no change to any register.
  - 001 load: q<=d; shift_cnt<=0; sout and cout<=0.
  - 010 shl: q<={q[W-2:0],sin}; sout<=q[W-1].
  - 011 shr (logical): q<={sin,q[W-1:1]}; sout<=q[0].
  - 100 sar: q<={q[W-1],q[W-1:1]}; sout<=q[0]; sin is ignored.
  - 101 inc: {cout,q}<=q+1, modulo 2^WIDTH; all-ones wraps to 0 with cout=1.
  - 110 dec: q<=q-1, modulo 2^WIDTH; cout<=1 only when q was 0 (borrow, 0 wraps to all-ones).
  - 111 clear: q<=0 (not RESET_VAL); shift_cnt<=0; sout and cout<=0.
- Shift ops (010/011/100): shift_cnt<=min(shift_cnt+1, WIDTH). cout holds.
- inc/dec: shift_cnt and sout hold.
- shift_done stays asserted while saturated. Further shifts still modify q, but the count does not wrap.
- zero and shift_done are derived only from current register state; there is no extra latency.

Test Plan:
- WIDTH=19: assert rst asynchronously between clk edges → q=0, sout=0, cout=0, shift_cnt=0 immediately, without waiting for a clock edge.
- load d=0x5A5A5 with en=1, then op=101 with en=0 for 3 cycles → q stays 0x5A5A5, shift_cnt=0.
- load 0x7FFFF, then inc → q=0x00000, cout=1, zero=1; then dec → q=0x7FFFF, cout=1; then dec → q=0x7FFFE, cout=0.
- load 0x40001, then sar → q=0x60000, sout=1; then shr with sin=0 → q=0x30000, sout=0; then shl with sin=1 → q=0x60001, sout=0.
- load 0x00001, then 19 consecutive shl with sin=0 → shift_done rises on the cycle after the 19th shift, q=0, last sout=1; a 20th shl keeps shift_cnt=19.
- After 5 shifts, op=111 → q=0, shift_cnt=0. Then assert rst mid-shift sequence with RESET_VAL=0x00ABC → q=0x00ABC, shift_cnt=0.
